// File: rtl/shifter_seq_pkg.sv
// shifter_seq_pkg: shared types and helpers for the pattern-shifter sequencer.
//   state_t    : sequencer FSM states (IDLE, RUN, HOLD)
//   CONT_W     : width of the pattern-select index (8 patterns)
//   next_index : computes the next pattern index under the wrap / end /
//                ping-pong rules, plus end-of-sequence and turnaround flags.
package shifter_seq_pkg;

  localparam int unsigned CONT_W = 3;

  typedef logic [CONT_W-1:0] cont_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    cont_t idx;   // next pattern index
    logic  fim;   // one-shot sequence reached its end (index holds)
    logic  flip;  // ping-pong turnaround: direction flag must toggle
  } adv_t;

  // The >= on the forward end recovers when cur has been left above a
  // freshly shrunk ult; the reverse path just walks down until it hits 0.
  function automatic adv_t next_index(input cont_t cur,
                                      input cont_t ult,
                                      input logic  dir,
                                      input logic  loop,
                                      input logic  bounce);
    adv_t r;
    r.idx  = cur;
    r.fim  = 1'b0;
    r.flip = 1'b0;
    if (!dir) begin
      if (cur >= ult) begin
        if (!loop) begin
          r.fim = 1'b1;
        end else if (bounce) begin
          r.idx  = (ult == '0) ? '0 : ult - cont_t'(1);
          r.flip = 1'b1;
        end else begin
          r.idx = '0;
        end
      end else begin
        r.idx = cur + cont_t'(1);
      end
    end else begin
      if (cur == '0) begin
        if (!loop) begin
          r.fim = 1'b1;
        end else if (bounce) begin
          r.idx  = (ult == '0) ? '0 : cont_t'(1);
          r.flip = 1'b1;
        end else begin
          r.idx = ult;
        end
      end else begin
        r.idx = cur - cont_t'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shifter_seq_presc.sv
// shifter_seq_presc: rate prescaler for the pattern sequencer.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (count -> 0)
//   clr     : synchronous clear (count -> 0)
//   en      : count enable; when tc is high the count wraps to 0 instead
//   periodo : terminal value (cycles per step minus 1)
//   tc      : count >= periodo; >= so a shrinking periodo cannot strand the count
module shifter_seq_presc #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] periodo,
  output logic             tc
);

  logic [DIV_W-1:0] count;

  assign tc = (count >= periodo);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/shifter_sequencer.sv
// shifter_sequencer: sole driver of the 3-bit pattern select (Contador) of the
// 8-way 16-bit pattern shifter. Steps P1..P8 at a programmable rate with
// run / pause / single-step and one-shot / loop control, forward or reverse.
//   Clock    : system clock, rising edge
//   Reset    : synchronous active-high reset
//   Start    : start from IDLE / resume from HOLD
//   Stop     : pause from RUN / abort from HOLD (highest priority)
//   Step     : single advance in IDLE or HOLD (ignored in RUN)
//   Dir      : 0 = increment, 1 = decrement
//   Loop     : 1 = wrap forever, 0 = one-shot
//   Periodo  : clock cycles per pattern minus 1
//   Ultimo   : index of last pattern used
//   Contador : pattern select (registered)
//   Ativo    : high while in RUN (registered)
//   Tick     : one-cycle pulse with each new Contador value (registered)
//   Fim      : one-cycle pulse when a one-shot sequence completes (registered)
// Optional: define SHIFTER_SEQ_PINGPONG_EN to add input Bounce; with Loop=1 and
// Bounce=1 the sequence reverses at each end instead of wrapping.
module shifter_sequencer
  import shifter_seq_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Step,
  input  logic              Dir,
  input  logic              Loop,
`ifdef SHIFTER_SEQ_PINGPONG_EN
  input  logic              Bounce,
`endif
  input  logic [DIV_W-1:0]  Periodo,
  input  logic [CONT_W-1:0] Ultimo,
  output logic [CONT_W-1:0] Contador,
  output logic              Ativo,
  output logic              Tick,
  output logic              Fim
);

  state_t state;
  logic   pp_dir;     // internal ping-pong direction flag
  logic   bounce_en;
  logic   eff_dir;
  logic   presc_clr;
  logic   presc_en;
  logic   presc_tc;
  adv_t   adv_run;
  adv_t   adv_step;

`ifdef SHIFTER_SEQ_PINGPONG_EN
  assign bounce_en = Bounce;
`else
  assign bounce_en = 1'b0;
`endif

  // With bouncing active the internal flag owns direction; otherwise Dir is
  // used live so a mid-run change applies at the next advance.
  assign eff_dir = bounce_en ? pp_dir : Dir;

  assign adv_run  = next_index(Contador, Ultimo, eff_dir, Loop, bounce_en);
  assign adv_step = next_index(Contador, Ultimo, eff_dir, 1'b1, bounce_en);

  // Prescaler is held at zero outside RUN/HOLD so every fresh start begins a
  // full period; Stop in RUN suppresses counting so HOLD freezes it exactly.
  assign presc_clr = (state == IDLE) || ((state == HOLD) && Stop);
  assign presc_en  = (state == RUN) && !Stop;

  shifter_seq_presc #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk     (Clock),
    .rst     (Reset),
    .clr     (presc_clr),
    .en      (presc_en),
    .periodo (Periodo),
    .tc      (presc_tc)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      Contador <= '0;
      Ativo    <= 1'b0;
      Tick     <= 1'b0;
      Fim      <= 1'b0;
      pp_dir   <= 1'b0;
    end else begin
      Tick <= 1'b0;
      Fim  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!Stop) begin
            if (Start) begin
              state    <= RUN;
              Ativo    <= 1'b1;
              Contador <= Dir ? Ultimo : '0;
              pp_dir   <= Dir;
            end else if (Step) begin
              Contador <= adv_step.idx;
              Tick     <= 1'b1;
              if (adv_step.flip) pp_dir <= ~pp_dir;
            end
          end
        end
        RUN: begin
          if (Stop) begin
            state <= HOLD;
            Ativo <= 1'b0;
          end else if (presc_tc) begin
            if (adv_run.fim) begin
              state <= IDLE;
              Ativo <= 1'b0;
              Fim   <= 1'b1;
            end else begin
              Contador <= adv_run.idx;
              Tick     <= 1'b1;
              if (adv_run.flip) pp_dir <= ~pp_dir;
            end
          end
        end
        HOLD: begin
          if (Stop) begin
            state    <= IDLE;
            Contador <= '0;
          end else if (Start) begin
            state <= RUN;
            Ativo <= 1'b1;
          end else if (Step) begin
            Contador <= adv_step.idx;
            Tick     <= 1'b1;
            if (adv_step.flip) pp_dir <= ~pp_dir;
          end
        end
        default: begin
          state <= IDLE;
          Ativo <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_sequencer.sv
module tb_shifter_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Stop;
  logic        Step;
  logic        Dir;
  logic        Loop;
`ifdef SHIFTER_SEQ_PINGPONG_EN
  logic        Bounce;
`endif
  logic [15:0] Periodo;
  logic [2:0]  Ultimo;
  logic [2:0]  Contador;
  logic        Ativo;
  logic        Tick;
  logic        Fim;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  shifter_sequencer #(
    .DIV_W (16)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Stop     (Stop),
    .Step     (Step),
    .Dir      (Dir),
    .Loop     (Loop),
`ifdef SHIFTER_SEQ_PINGPONG_EN
    .Bounce   (Bounce),
`endif
    .Periodo  (Periodo),
    .Ultimo   (Ultimo),
    .Contador (Contador),
    .Ativo    (Ativo),
    .Tick     (Tick),
    .Fim      (Fim)
  );

  // Inputs change just after the falling edge; outputs are read there too,
  // i.e. half a period after the rising edge that produced them.
  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Step = 1'b0;
    Dir = 1'b0; Loop = 1'b1; Periodo = 16'd0; Ultimo = 3'd7;
`ifdef SHIFTER_SEQ_PINGPONG_EN
    Bounce = 1'b0;
`endif
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({Contador, Ativo, Tick, Fim} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got C=%0d A=%b T=%b F=%b want all 0", Contador, Ativo, Tick, Fim);
    end
    @(negedge Clock);
    total++;
    if ({Contador, Ativo, Tick, Fim} !== 6'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got C=%0d A=%b T=%b F=%b want all 0", Contador, Ativo, Tick, Fim);
    end
  endtask

  task automatic test_forward_loop();
    logic [2:0] exp_c;
    do_reset();
    Periodo = 16'd2; Ultimo = 3'd7; Loop = 1'b1; Dir = 1'b0;
    pulse_start();
    total++;
    if ({Contador, Ativo, Tick} !== {3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL fwd_start: got C=%0d A=%b T=%b want C=0 A=1 T=0", Contador, Ativo, Tick);
    end
    exp_c = 3'd0;
    for (int i = 1; i <= 26; i++) begin
      @(negedge Clock);
      if (i % 3 == 0) exp_c = exp_c + 3'd1;
      total++;
      if ({Contador, Tick, Fim} !== {exp_c, (i % 3 == 0), 1'b0}) begin
        bad++;
        $display("FAIL fwd_loop cyc%0d: got C=%0d T=%b F=%b want C=%0d T=%b F=0",
                 i, Contador, Tick, Fim, exp_c, (i % 3 == 0));
      end
    end
  endtask

  task automatic test_oneshot_reverse();
    do_reset();
    Dir = 1'b1; Ultimo = 3'd3; Loop = 1'b0; Periodo = 16'd0;
    pulse_start();
    total++;
    if ({Contador, Ativo} !== {3'd3, 1'b1}) begin
      bad++;
      $display("FAIL rev_start: got C=%0d A=%b want C=3 A=1", Contador, Ativo);
    end
    for (int v = 2; v >= 0; v--) begin
      @(negedge Clock);
      total++;
      if ({Contador, Tick, Fim} !== {3'(v), 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL rev_step: got C=%0d T=%b F=%b want C=%0d T=1 F=0", Contador, Tick, Fim, v);
      end
    end
    @(negedge Clock);
    total++;
    if ({Contador, Ativo, Tick, Fim} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rev_fim: got C=%0d A=%b T=%b F=%b want C=0 A=0 T=0 F=1", Contador, Ativo, Tick, Fim);
    end
    @(negedge Clock);
    total++;
    if ({Contador, Ativo, Fim} !== {3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rev_after_fim: got C=%0d A=%b F=%b want C=0 A=0 F=0", Contador, Ativo, Fim);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    Dir = 1'b0; Ultimo = 3'd7; Loop = 1'b1; Periodo = 16'd4;
    pulse_start();
    // two counting cycles bring the prescaler to 2
    @(negedge Clock);
    @(negedge Clock);
    Stop = 1'b1;
    @(negedge Clock);
    Stop = 1'b0;
    total++;
    if ({Contador, Ativo} !== {3'd0, 1'b0}) begin
      bad++;
      $display("FAIL pause_enter: got C=%0d A=%b want C=0 A=0", Contador, Ativo);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      total++;
      if ({Contador, Tick} !== {3'd0, 1'b0}) begin
        bad++;
        $display("FAIL pause_frozen cyc%0d: got C=%0d T=%b want C=0 T=0", i, Contador, Tick);
      end
    end
    pulse_start();
    total++;
    if ({Contador, Ativo} !== {3'd0, 1'b1}) begin
      bad++;
      $display("FAIL resume: got C=%0d A=%b want C=0 A=1", Contador, Ativo);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clock);
      total++;
      if ({Contador, Tick} !== {((i == 3) ? 3'd1 : 3'd0), (i == 3)}) begin
        bad++;
        $display("FAIL resume_adv cyc%0d: got C=%0d T=%b want C=%0d T=%b",
                 i, Contador, Tick, (i == 3), (i == 3));
      end
    end
  endtask

  task automatic test_step();
    do_reset();
    Dir = 1'b0; Ultimo = 3'd5; Loop = 1'b1; Periodo = 16'd0;
    pulse_start();
    repeat (5) @(negedge Clock);
    Stop = 1'b1;
    @(negedge Clock);
    Stop = 1'b0;
    total++;
    if ({Contador, Ativo} !== {3'd5, 1'b0}) begin
      bad++;
      $display("FAIL step_hold: got C=%0d A=%b want C=5 A=0", Contador, Ativo);
    end
    Step = 1'b1;
    @(negedge Clock);
    Step = 1'b0;
    total++;
    if ({Contador, Tick, Fim} !== {3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL step_wrap: got C=%0d T=%b F=%b want C=0 T=1 F=0", Contador, Tick, Fim);
    end
    @(negedge Clock);
    total++;
    if ({Contador, Tick} !== {3'd0, 1'b0}) begin
      bad++;
      $display("FAIL step_single: got C=%0d T=%b want C=0 T=0", Contador, Tick);
    end
    Step = 1'b1;
    @(negedge Clock);
    Step = 1'b0;
    total++;
    if ({Contador, Tick} !== {3'd1, 1'b1}) begin
      bad++;
      $display("FAIL step_inc: got C=%0d T=%b want C=1 T=1", Contador, Tick);
    end
    Stop = 1'b1; Start = 1'b1;
    @(negedge Clock);
    Stop = 1'b0; Start = 1'b0;
    total++;
    if ({Contador, Ativo} !== {3'd0, 1'b0}) begin
      bad++;
      $display("FAIL abort_hold: got C=%0d A=%b want C=0 A=0", Contador, Ativo);
    end
    // reverse step from 0 in IDLE wraps to Ultimo
    Dir = 1'b1; Step = 1'b1;
    @(negedge Clock);
    Step = 1'b0;
    total++;
    if ({Contador, Tick, Ativo} !== {3'd5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL step_rev_wrap: got C=%0d T=%b A=%b want C=5 T=1 A=0", Contador, Tick, Ativo);
    end
  endtask

  task automatic test_shrink_and_reset();
    do_reset();
    Dir = 1'b0; Ultimo = 3'd7; Loop = 1'b1; Periodo = 16'd0;
    pulse_start();
    repeat (6) @(negedge Clock);
    total++;
    if (Contador !== 3'd6) begin
      bad++;
      $display("FAIL shrink_pre: got C=%0d want C=6", Contador);
    end
    Ultimo = 3'd2;
    @(negedge Clock);
    total++;
    if ({Contador, Tick, Fim} !== {3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL shrink_wrap: got C=%0d T=%b F=%b want C=0 T=1 F=0", Contador, Tick, Fim);
    end
    Periodo = 16'd5;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    total++;
    if ({Contador, Ativo, Tick, Fim} !== 6'b0) begin
      bad++;
      $display("FAIL reset_midrun: got C=%0d A=%b T=%b F=%b want all 0", Contador, Ativo, Tick, Fim);
    end
    // restart with Periodo=1: a cleared prescaler gives the first advance 2 cycles in
    Periodo = 16'd1;
    pulse_start();
    @(negedge Clock);
    total++;
    if ({Contador, Tick} !== {3'd0, 1'b0}) begin
      bad++;
      $display("FAIL post_reset_wait: got C=%0d T=%b want C=0 T=0", Contador, Tick);
    end
    @(negedge Clock);
    total++;
    if ({Contador, Tick} !== {3'd1, 1'b1}) begin
      bad++;
      $display("FAIL post_reset_adv: got C=%0d T=%b want C=1 T=1", Contador, Tick);
    end
  endtask

`ifdef SHIFTER_SEQ_PINGPONG_EN
  task automatic test_pingpong();
    logic [2:0] seq [7];
    seq = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    do_reset();
    Bounce = 1'b1; Ultimo = 3'd2; Periodo = 16'd0; Loop = 1'b1; Dir = 1'b0;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      total++;
      if (Contador !== seq[i]) begin
        bad++;
        $display("FAIL pingpong idx%0d: got C=%0d want C=%0d", i, Contador, seq[i]);
      end
      @(negedge Clock);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward_loop();
    test_oneshot_reverse();
    test_pause_resume();
    test_step();
    test_shrink_and_reset();
`ifdef SHIFTER_SEQ_PINGPONG_EN
    test_pingpong();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shifter_sequencer.md
# shifter_sequencer

Sequencer that drives the 3-bit pattern-select `Contador` of the 8-way, 16-bit pattern shifter mux. It steps through patterns P1..P8 at a programmable rate, with:
- run, pause, single-step and one-shot/loop control;
- forward or reverse direction.

It sits between the front-panel/control logic and the shifter datapath and is the only source of `Contador`.

## Interface
Parameters:
- `DIV_W`, 16, width of the prescaler and of `Periodo`

Ports:
- `Clock`  in  1  system clock, all state on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Start`  in  1  start from IDLE / resume from HOLD (level sampled per cycle)
- `Stop`  in  1  pause from RUN / abort from HOLD
- `Step`  in  1  single advance when in IDLE or HOLD
- `Dir`  in  1  0 = increment, 1 = decrement
- `Loop`  in  1  1 = wrap forever, 0 = one-shot
- `Periodo`  in  DIV_W  clock cycles per pattern minus 1
- `Ultimo`  in  3  index of last pattern used (0..7)
- `Contador`  out  3  pattern select to shifter
- `Ativo`  out  1  high in RUN
- `Tick`  out  1  one-cycle pulse coincident with each new `Contador` value
- `Fim`  out  1  one-cycle pulse when a one-shot sequence completes

## Operation
The FSM has three states: IDLE, RUN and HOLD. Reset forces:
- state IDLE;
- `Contador` = 0, prescaler = 0;
- `Ativo` = `Tick` = `Fim` = 0.

Command priority is Stop > Start > Step. Step is ignored in RUN.

State transitions:
- **IDLE + Start** → RUN. `Contador` loads 0 if `Dir`=0, else `Ultimo`. Prescaler clears.
- **RUN:** the prescaler counts up. When prescaler ≥ `Periodo`, it clears, `Contador` advances and `Tick` pulses.
- **Advance, `Dir`=0:**
  - If `Contador` ≥ `Ultimo`: next value is 0 when `Loop`=1.
  - When `Loop`=0 instead: `Contador` holds, `Fim` pulses, state → IDLE.
  - Otherwise `Contador` = `Contador`+1.
- **Advance, `Dir`=1:**
  - If `Contador` = 0: next value is `Ultimo` when `Loop`=1.
  - When `Loop`=0 instead: hold, `Fim` pulses, state → IDLE.
  - Otherwise `Contador` = `Contador`-1.
- **RUN + Stop** → HOLD. `Contador` and prescaler are frozen.
- **HOLD + Start** → RUN. The prescaler resumes from its frozen value.
- **HOLD + Stop** → IDLE. `Contador` = 0.
- **Step in IDLE/HOLD:** one advance per asserted cycle, with the same wrap rules. `Loop` is treated as 1, so Step never produces `Fim`. `Tick` pulses.
- **Inputs changed mid-run:** `Ultimo`, `Periodo` and `Dir` take effect at the next comparison. The ≥ comparisons guarantee recovery when `Contador` > `Ultimo` or prescaler > `Periodo`.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Start sampled in cycle n → `Ativo`=1 and the initial `Contador` are visible in n+1.
- First advance occurs `Periodo`+1 cycles after entering RUN. `Periodo`=0 advances every cycle.
- `Tick` and `Fim` are high for exactly one cycle, in the same cycle the new `Contador` (or final hold) is visible.
- Step sampled in cycle n → new `Contador` and `Tick` in n+1.
- Reset asserted in any cycle, mid-run included → reset values in the next cycle. Reset overrides all commands.

## Configuration
- `SHIFTER_SEQ_PINGPONG_EN` defined:
  - Adds input port `Bounce` (1 bit).
  - With `Loop`=1 and `Bounce`=1, reaching an end reverses an internal direction flag instead of wrapping: 0,1,…,`Ultimo`,`Ultimo`-1,…,0,1…
  - The internal flag loads from `Dir` on Start and clears on Reset.
- Not defined: `Bounce` is absent and the wrap behaviour above is the only loop mode.

## Structure
- Package `shifter_seq_pkg` holds:
  - the state enum (IDLE, RUN, HOLD);
  - `CONT_W` = 3;
  - the next-index function implementing the wrap/end rules.
- One sub-module, `shifter_seq_presc`: DIV_W-bit prescaler with clear, enable and terminal-count (≥ `Periodo`) output.

## Test plan
- **Forward loop:** Reset; `Periodo`=2, `Ultimo`=7, `Loop`=1, `Dir`=0, pulse Start → `Contador` 0,1,…,7,0 changing every 3 cycles, `Tick` each change, `Fim` never.
- **One-shot reverse:** `Dir`=1, `Ultimo`=3, `Loop`=0, `Periodo`=0, Start → `Contador` 3,2,1,0. Next cycle `Fim`=1, `Ativo`=0, `Contador` stays 0.
- **Pause/resume:** RUN with `Periodo`=4, Stop when prescaler=2 → `Contador` frozen for 10 cycles. Start → next advance exactly 3 cycles later.
- **Step:** In HOLD at `Contador`=5 with `Ultimo`=5, assert Step 1 cycle → `Contador`=0, `Tick`=1. Stop+Start asserted together in HOLD → IDLE, `Contador`=0.
- **Reset mid-run and `Ultimo` shrink:** In RUN at `Contador`=6, set `Ultimo`=2 → next advance gives 0. Reset mid-period → all outputs 0 next cycle.
- **Ping-pong (`SHIFTER_SEQ_PINGPONG_EN` only):** `Bounce`=1, `Ultimo`=2, `Periodo`=0 → `Contador` 0,1,2,1,0,1,2.
